// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: parametrised chain of pipeline registers with
// per-stage stall, bubble insertion, flush and multicycle sideband.
// Ports:
//   clk, rst        clock (rising edge), async active-high reset
//   stall           [STAGES:0] stall[k] stops position k
//   flush           [STAGES-1:0] kill stage k contents
//   in_valid/in_data stage-0 input
//   side_i          per-stage sideband returned by consumer (slice k)
//   out_valid       per-stage valid
//   out_data        per-stage payload (slice k)
//   side_o          per-stage held sideband (slice k)
//   bubble_cnt      saturating count of last-stage bubbles
module pipe_stage_chain #(
    parameter int                STAGES     = 2,
    parameter int                DATA_W     = 32,
    parameter int                SIDE_W     = 66,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
    parameter bit                SIDE_FLUSH = 1'b1,
    parameter int                CNT_W      = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [STAGES:0]          stall,
    input  logic [STAGES-1:0]        flush,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [STAGES*SIDE_W-1:0] side_i,
    output logic [STAGES-1:0]        out_valid,
    output logic [STAGES*DATA_W-1:0] out_data,
    output logic [STAGES*SIDE_W-1:0] side_o,
    output logic [CNT_W-1:0]         bubble_cnt
);

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic              in_v;
        logic [DATA_W-1:0] in_d;
        logic              valid_q, valid_d;
        logic [DATA_W-1:0] data_q, data_d;
        logic [SIDE_W-1:0] side_q, side_d;

        if (k == 0) begin : g_head
            assign in_v = in_valid;
            assign in_d = in_data;
        end else begin : g_link
            assign in_v = out_valid[k-1];
            assign in_d = out_data[(k-1)*DATA_W +: DATA_W];
        end

        // Priority: flush, advance, bubble, hold.
        always_comb begin
            valid_d = valid_q;
            data_d  = data_q;
            side_d  = side_q;
            if (flush[k]) begin
                valid_d = 1'b0;
                data_d  = BUBBLE_VAL;
                if (SIDE_FLUSH) begin
                    side_d = '0;
                end
            end else if (!stall[k]) begin
                valid_d = in_v;
                data_d  = in_d;
                side_d  = '0;
            end else if (!stall[k+1]) begin
                valid_d = 1'b0;
                data_d  = BUBBLE_VAL;
                side_d  = side_i[k*SIDE_W +: SIDE_W];
            end else begin
                side_d  = side_i[k*SIDE_W +: SIDE_W];
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_q <= 1'b0;
                data_q  <= BUBBLE_VAL;
                side_q  <= '0;
            end else begin
                valid_q <= valid_d;
                data_q  <= data_d;
                side_q  <= side_d;
            end
        end

        assign out_valid[k]                = valid_q;
        assign out_data[k*DATA_W +: DATA_W] = data_q;
        assign side_o[k*SIDE_W +: SIDE_W]   = side_q;
    end

    logic             last_bubble;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Last stage takes the bubble rule only when it is not flushed.
    assign last_bubble = !flush[STAGES-1] && stall[STAGES-1]
                         && !stall[STAGES];

    always_comb begin
        cnt_d = cnt_q;
        if (last_bubble && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bubble_cnt = cnt_q;

endmodule
